// File: rtl/addx_simd_accel.sv
// Packed-SIMD saturating add/subtract unit (8/16/32/64-bit lanes) with an
// elastic result pipeline, a sticky saturation flag and a saturation counter.
module addx_simd_accel #(
  parameter int XLEN          = 64,
  parameter int PIPE_STAGES   = 2,
  parameter int TRANS_ID_BITS = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [1:0]               op_i,
  input  logic [1:0]               ewidth_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic                     sat_o,
  output logic                     vxsat_o,
  input  logic                     vxsat_clr_i,
  output logic [CNT_WIDTH-1:0]     sat_cnt_o
);

  localparam int         LAST   = PIPE_STAGES - 1;
  localparam logic [1:0] MAX_EW = (XLEN == 64) ? 2'd3 : 2'd2;

  logic [XLEN-1:0] width_res [4];
  logic            width_sat [4];

  // One saturating lane array per element width; the decoded width picks one.
  for (genvar g = 0; g < 4; g++) begin : g_width
    localparam int W = 8 << g;
    if (W <= XLEN) begin : g_on
      localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
      localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
      logic [XLEN-1:0]   res_c;
      logic [XLEN/W-1:0] sat_c;
      logic [W-1:0]      a, b;
      logic [W:0]        sum, dif;

      always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        res_c = '0;
        sat_c = '0;
        a     = '0;
        b     = '0;
        sum   = '0;
        dif   = '0;
        for (int l = 0; l < XLEN/W; l++) begin
          a   = operand_a_i[l*W +: W];
          b   = operand_b_i[l*W +: W];
          sum = {1'b0, a} + {1'b0, b};
          dif = {1'b0, a} - {1'b0, b};
          case (op_i)
            2'd0: begin
              res_c[l*W +: W] = sum[W-1:0];
              if (a[W-1] == b[W-1] && sum[W-1] != a[W-1]) begin
                sat_c[l]        = 1'b1;
                res_c[l*W +: W] = a[W-1] ? SMIN : SMAX;
              end
            end
            2'd1: begin
              res_c[l*W +: W] = dif[W-1:0];
              if (a[W-1] != b[W-1] && dif[W-1] != a[W-1]) begin
                sat_c[l]        = 1'b1;
                res_c[l*W +: W] = a[W-1] ? SMIN : SMAX;
              end
            end
            2'd2: begin
              sat_c[l]        = sum[W];
              res_c[l*W +: W] = sum[W] ? {W{1'b1}} : sum[W-1:0];
            end
            2'd3: begin
              sat_c[l]        = dif[W];
              res_c[l*W +: W] = dif[W] ? {W{1'b0}} : dif[W-1:0];
            end
          endcase
        end
      end

      assign width_res[g] = res_c;
      assign width_sat[g] = |sat_c;
    end else begin : g_off
      assign width_res[g] = '0;
      assign width_sat[g] = 1'b0;
    end
  end

  logic [1:0]      eff_ew;
  logic [XLEN-1:0] comp_res;
  logic            comp_sat;

  assign eff_ew   = (ewidth_i > MAX_EW) ? MAX_EW : ewidth_i;
  assign comp_res = width_res[eff_ew];
  assign comp_sat = width_sat[eff_ew];

  logic [PIPE_STAGES-1:0]                    valid_q, valid_d, adv;
  logic [PIPE_STAGES-1:0][XLEN-1:0]          res_q, res_d;
  logic [PIPE_STAGES-1:0][TRANS_ID_BITS-1:0] id_q, id_d;
  logic [PIPE_STAGES-1:0]                    sat_q, sat_d;
  logic                                      vxsat_q, vxsat_d;
  logic [CNT_WIDTH-1:0]                      sat_cnt_q, sat_cnt_d;
  logic                                      room;
  logic                                      deliver;

  // A stage advances when some stage at or after it is empty or the consumer takes.
  always_comb begin
    room = ready_i;
    adv  = '0;
    for (int i = LAST; i >= 0; i--) begin
      room   = room | ~valid_q[i];
      adv[i] = room;
    end
  end

  assign ready_o = adv[0];
  assign deliver = valid_q[LAST] & ready_i;

  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    id_d    = id_q;
    sat_d   = sat_q;
    if (adv[0]) begin
      valid_d[0] = valid_i;
      res_d[0]   = comp_res;
      id_d[0]    = trans_id_i;
      sat_d[0]   = comp_sat;
    end
    for (int i = 1; i < PIPE_STAGES; i++) begin
      if (adv[i]) begin
        valid_d[i] = valid_q[i-1];
        res_d[i]   = res_q[i-1];
        id_d[i]    = id_q[i-1];
        sat_d[i]   = sat_q[i-1];
      end
    end
    if (flush_i) valid_d = '0;
  end

  always_comb begin
    vxsat_d   = vxsat_q;
    sat_cnt_d = sat_cnt_q;
    if (vxsat_clr_i)            vxsat_d = 1'b0;
    if (deliver && sat_q[LAST]) begin
      vxsat_d = 1'b1;
      if (sat_cnt_q != '1) sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      // NOTE: payload registers are reset as well so result, tag and sat read 0.
      valid_q   <= '0;
      res_q     <= '0;
      id_q      <= '0;
      sat_q     <= '0;
      vxsat_q   <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      res_q     <= res_d;
      id_q      <= id_d;
      sat_q     <= sat_d;
      vxsat_q   <= vxsat_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign valid_o    = valid_q[LAST];
  assign result_o   = res_q[LAST];
  assign trans_id_o = id_q[LAST];
  assign sat_o      = sat_q[LAST];
  assign vxsat_o    = vxsat_q;
  assign sat_cnt_o  = sat_cnt_q;

endmodule
